// File: rtl/serial_compare_if.sv
// serial_compare_if
//   Bundles the request and result signals of the bit-serial comparator.
//   master : the requester; drives start, signed_en, a, b and observes the
//            busy/done handshake plus the registered result flags.
//   slave  : the comparator itself.
//   Signals:
//     start      request a comparison (sampled on the rising clock)
//     signed_en  1 = two's-complement compare, 0 = unsigned
//     a, b       operands, WIDTH bits each
//     busy       high while a comparison is in progress
//     done       one-cycle pulse when a new result is valid
//     gt/eq/lt   one-hot result flags (A>B, A==B, A<B)
//     bits_used  number of bit positions examined for the last result
interface serial_compare_if #(
  parameter int WIDTH = 8
);
  localparam int BW = $clog2(WIDTH) + 1;

  logic             start;
  logic             signed_en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;
  logic [BW-1:0]    bits_used;

  modport master (
    output start, signed_en, a, b,
    input  busy, done, gt, eq, lt, bits_used
  );

  modport slave (
    input  start, signed_en, a, b,
    output busy, done, gt, eq, lt, bits_used
  );
endinterface

// File: rtl/serial_compare.sv
// serial_compare
//   Bit-serial magnitude comparator. Operands are latched on an accepted
//   start and scanned one bit per cycle from the MSB down; the scan stops at
//   the first differing bit or after bit 0. Results are registered and held
//   until the next comparison completes.
//   Ports:
//     clk    single clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    serial_compare_if.slave (start/signed_en/a/b in,
//            busy/done/gt/eq/lt/bits_used out)
module serial_compare #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_compare_if.slave   bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             signed_q;
  logic [IW-1:0]    idx_q;

  logic             gt_q;
  logic             eq_q;
  logic             lt_q;
  logic [BW-1:0]    bits_used_q;

  logic             load;
  logic             finish;
  logic             bit_a;
  logic             bit_b;
  logic             res_gt;
  logic             res_eq;
  logic             res_lt;
  logic [BW-1:0]    bits_used_d;

  assign bit_a = a_q[idx_q];
  assign bit_b = b_q[idx_q];

  // Bits examined so far, counting the one under the index this cycle.
  assign bits_used_d = BW'(WIDTH) - BW'(idx_q);

  // Decision for the bit currently under the index. At the sign bit of a
  // signed compare the operand holding a 1 is the negative one, so the
  // sense of the decision flips there.
  always_comb begin
    res_gt = 1'b0;
    res_eq = 1'b0;
    res_lt = 1'b0;
    if (bit_a != bit_b) begin
      if (signed_q && (idx_q == IW'(WIDTH - 1))) begin
        res_lt = bit_a;
        res_gt = bit_b;
      end else begin
        res_gt = bit_a;
        res_lt = bit_b;
      end
    end else begin
      res_eq = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A new request is accepted from IDLE and also from
  // DONE so that back-to-back comparisons need no idle gap. In SHIFT the
  // start input is not looked at.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!res_eq || (idx_q == '0)) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture and bit index. The index only walks down while the
  // scan continues; on the finishing cycle it is left where it stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
    end else if (load) begin
      a_q      <= bus.a;
      b_q      <= bus.b;
      signed_q <= bus.signed_en;
      idx_q    <= IW'(WIDTH - 1);
    end else if ((state_q == SHIFT) && !finish) begin
      idx_q    <= idx_q - 1'b1;
    end
  end

  // Result flags are written only on the edge that enters DONE, so the
  // previous result stays visible throughout the next scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      bits_used_q <= '0;
    end else if (finish) begin
      gt_q        <= res_gt;
      eq_q        <= res_eq;
      lt_q        <= res_lt;
      bits_used_q <= bits_used_d;
    end
  end

  assign bus.busy      = (state_q == SHIFT);
  assign bus.done      = (state_q == DONE);
  assign bus.gt        = gt_q;
  assign bus.eq        = eq_q;
  assign bus.lt        = lt_q;
  assign bus.bits_used = bits_used_q;
endmodule

// File: tb/tb_serial_compare.sv
// tb_serial_compare
//   Directed, table-driven bench for serial_compare at WIDTH=8, plus
//   hand-written sequences for ignored start, back-to-back requests and
//   reset in the middle of a scan.
module tb_serial_compare;
  localparam int WIDTH = 8;
  localparam int BW    = $clog2(WIDTH) + 1;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       sgn;
    logic [2:0] flags;
    int         used;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_compare_if #(.WIDTH(WIDTH)) bus ();

  serial_compare #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value against its expectation and tally the outcome.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [2:0] flagsNow();
    return {bus.gt, bus.eq, bus.lt};
  endfunction

  // Run one full comparison. Start is driven at a falling edge so the next
  // rising edge accepts it; cycles are counted from that accept edge, so a
  // result needing n bits shows done on sample n+1.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic sgn, output int cycles,
                               output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    @(negedge clk);
    bus.a         = a;
    bus.b         = b;
    bus.signed_en = sgn;
    bus.start     = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cycles++;
      if (bus.busy) busy_cycles++;
      if (bus.done) break;
    end
    if (!bus.done) cycles = 999;
  endtask

  initial begin
    vec_t vecs[$];
    int   cyc;
    int   bcyc;
    int   done_cnt;
    int   held_bad;
    int   stray;

    total = 0;
    bad   = 0;

    vecs.push_back('{"unsigned_late",   8'hA5, 8'hA4, 1'b0, 3'b100, 8});
    vecs.push_back('{"msb_unsigned",    8'h80, 8'h7F, 1'b0, 3'b100, 1});
    vecs.push_back('{"msb_signed",      8'h80, 8'h7F, 1'b1, 3'b001, 1});
    vecs.push_back('{"equal_unsigned",  8'h3C, 8'h3C, 1'b0, 3'b010, 8});
    vecs.push_back('{"equal_signed",    8'h3C, 8'h3C, 1'b1, 3'b010, 8});
    vecs.push_back('{"bit1_lt",         8'h01, 8'h02, 1'b0, 3'b001, 7});
    vecs.push_back('{"neg1_vs_1",       8'hFF, 8'h01, 1'b1, 3'b001, 1});
    vecs.push_back('{"ff_vs_1_uns",     8'hFF, 8'h01, 1'b0, 3'b100, 1});
    vecs.push_back('{"pos_mid_gt",      8'h7F, 8'h70, 1'b1, 3'b100, 5});
    vecs.push_back('{"neg_mid_lt",      8'hF0, 8'hF8, 1'b1, 3'b001, 5});
    vecs.push_back('{"zero_eq",         8'h00, 8'h00, 1'b1, 3'b010, 8});
    vecs.push_back('{"bit0_lt",         8'h10, 8'h11, 1'b0, 3'b001, 8});

    // Reset state: everything low while rst_n is held.
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.signed_en = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy",  32'(bus.busy), 32'd0);
    checkOutput("reset_done",  32'(bus.done), 32'd0);
    checkOutput("reset_flags", 32'(flagsNow()), 32'd0);
    checkOutput("reset_used",  32'(bus.bits_used), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of single comparisons.
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].a, vecs[k].b, vecs[k].sgn, cyc, bcyc);
      checkOutput({vecs[k].name, "_flags"}, 32'(flagsNow()), 32'(vecs[k].flags));
      checkOutput({vecs[k].name, "_used"}, 32'(bus.bits_used), 32'(vecs[k].used));
      checkOutput({vecs[k].name, "_latency"}, 32'(cyc), 32'(vecs[k].used + 1));
      checkOutput({vecs[k].name, "_busycyc"}, 32'(bcyc), 32'(vecs[k].used));
      @(posedge clk);
      #1;
      checkOutput({vecs[k].name, "_donepulse"}, 32'({bus.done, bus.busy}), 32'd0);
      checkOutput({vecs[k].name, "_hold"}, 32'(flagsNow()), 32'(vecs[k].flags));
    end

    // Ignored start: a second request with a=0 arrives mid-scan and must
    // not disturb the running A5 vs A4 compare or add a done pulse.
    @(negedge clk);
    bus.a         = 8'hA5;
    bus.b         = 8'hA4;
    bus.signed_en = 1'b0;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.a     = 8'h00;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    done_cnt  = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_cnt++;
    end
    checkOutput("ignore_done_count", 32'(done_cnt), 32'd1);
    checkOutput("ignore_flags", 32'(flagsNow()), 32'b100);
    checkOutput("ignore_used", 32'(bus.bits_used), 32'd8);

    // Back-to-back: start stays high through the DONE cycle of an MSB
    // early exit, so the next compare starts immediately.
    @(negedge clk);
    bus.a         = 8'h80;
    bus.b         = 8'h7F;
    bus.signed_en = 1'b0;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.a = 8'h3C;
    bus.b = 8'h3C;
    @(posedge clk);
    #1;
    checkOutput("b2b_first_done", 32'(bus.done), 32'd1);
    checkOutput("b2b_first_flags", 32'(flagsNow()), 32'b100);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("b2b_no_gap_busy", 32'({bus.busy, bus.done}), 32'b10);
    held_bad = 0;
    cyc      = 1;
    while (!bus.done && cyc < 30) begin
      if (flagsNow() !== 3'b100 || bus.bits_used !== BW'(1)) held_bad++;
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("b2b_flags_held", 32'(held_bad), 32'd0);
    checkOutput("b2b_second_latency", 32'(cyc), 32'd9);
    checkOutput("b2b_second_flags", 32'(flagsNow()), 32'b010);
    checkOutput("b2b_second_used", 32'(bus.bits_used), 32'd8);

    // Reset in the middle of a scan: outputs clear at once, and the
    // abandoned comparison never produces a done pulse.
    @(negedge clk);
    bus.a         = 8'hA5;
    bus.b         = 8'hA4;
    bus.signed_en = 1'b0;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
    checkOutput("midreset_flags", 32'(flagsNow()), 32'd0);
    checkOutput("midreset_used", 32'(bus.bits_used), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) stray++;
    end
    checkOutput("midreset_no_done", 32'(stray), 32'd0);

    // The first edge after reset release must accept a pending start.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n         = 1'b1;
    bus.a         = 8'h80;
    bus.b         = 8'h7F;
    bus.signed_en = 1'b1;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("release_accept_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("release_done", 32'(bus.done), 32'd1);
    checkOutput("release_flags", 32'(flagsNow()), 32'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
